// File: rtl/rmux_capture_seq.sv
// rmux_capture_seq
// Sequencer and holding register sitting behind a WIDTH-wide bank of RMUX
// AND-NOR cells (RN = ~(A&RA | D&RD)). One request drives one strobe (RA or
// RD), waits SETTLE cycles for the bank to resolve, then captures ~RN_BUS
// into the held register and pulses R_VLD for one cycle.
// While the block is quiet it watches RN_BUS: a bus that is not all ones
// during idle points at a stuck or contended cell, and sets the sticky ERR.
// Optional feature: define RMUX_CAPTURE_PARITY_EN to register even parity
// of the held value on R_PAR. Without it R_PAR is tied low.

module rmux_capture_seq #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 2
) (
    input  logic             sysclk,
    input  logic             sys_rst_n,
    input  logic             REQ,
    input  logic             SRC,
    output logic             RDY,
    output logic             RA,
    output logic             RD,
    input  logic [WIDTH-1:0] RN_BUS,
    input  logic             CLR,
    output logic [WIDTH-1:0] R_OUT,
    output logic             R_VLD,
    output logic             R_PAR,
    output logic             ERR
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STROBE,
        ST_SETTLE,
        ST_CAPT
    } stateT;

    // The counter is 4 bits wide, so the largest settle time is 15 cycles
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    stateT            state;
    stateT            nextState;
    logic             srcLat;
    logic [3:0]       settleCnt;
    logic             raReg;
    logic             rdReg;
    logic [WIDTH-1:0] rOut;
    logic             errReg;
    logic             idleRun;
    logic             quietNow;
    logic             accept;
    logic             clrIdle;
    logic             strobeNext;

    // State register; reset returns to idle at once, even mid-operation
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode plus the handshake outputs that follow the state
    always_comb begin
        nextState  = state;
        RDY        = 1'b0;
        R_VLD      = 1'b0;
        accept     = 1'b0;
        clrIdle    = 1'b0;
        strobeNext = 1'b0;
        case (state)
            ST_IDLE: begin
                RDY = 1'b1;
                if (REQ) begin
                    accept    = 1'b1;
                    nextState = ST_STROBE;
                end else if (CLR) begin
                    clrIdle = 1'b1;
                end
            end
            ST_STROBE: begin
                strobeNext = 1'b1;
                nextState  = ST_SETTLE;
            end
            ST_SETTLE: begin
                strobeNext = 1'b1;
                if (settleCnt == 4'd0) begin
                    nextState = ST_CAPT;
                end
            end
            ST_CAPT: begin
                R_VLD     = 1'b1;
                nextState = ST_IDLE;
            end
            default: begin
                nextState = ST_IDLE;
            end
        endcase
    end

    // Latch the source select on accept; later SRC changes are ignored
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            srcLat <= 1'b0;
        end else if (accept) begin
            srcLat <= SRC;
        end
    end

    // Settle counter: loaded in STROBE, counts down through SETTLE to zero
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            settleCnt <= 4'd0;
        end else if (state == ST_STROBE) begin
            settleCnt <= CNT_LOAD;
        end else if (state == ST_SETTLE && settleCnt != 4'd0) begin
            settleCnt <= settleCnt - 4'd1;
        end
    end

    // Registered strobes: high from the edge leaving STROBE until the edge
    // leaving CAPT, only one of them ever set, both cleared by reset
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            raReg <= 1'b0;
            rdReg <= 1'b0;
        end else begin
            raReg <= strobeNext & ~srcLat;
            rdReg <= strobeNext & srcLat;
        end
    end

    assign RA = raReg;
    assign RD = rdReg;

    // Held register: takes the true-polarity bus in CAPT, clears on an idle CLR
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rOut <= '0;
        end else if (state == ST_CAPT) begin
            rOut <= ~RN_BUS;
        end else if (clrIdle) begin
            rOut <= '0;
        end
    end

    assign R_OUT = rOut;

`ifdef RMUX_CAPTURE_PARITY_EN
    logic rPar;

    // Parity of the held value, updated on exactly the same edges as R_OUT
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rPar <= 1'b0;
        end else if (state == ST_CAPT) begin
            rPar <= ^(~RN_BUS);
        end else if (clrIdle) begin
            rPar <= 1'b0;
        end
    end

    assign R_PAR = rPar;
`else
    assign R_PAR = 1'b0;
`endif

    // The bank is quiet when idle with both strobes low; the first quiet
    // cycle after a capture is a grace cycle while the cells recover
    assign quietNow = (state == ST_IDLE) & ~raReg & ~rdReg;

    // Remember whether the previous cycle was already quiet
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idleRun <= 1'b0;
        end else begin
            idleRun <= quietNow;
        end
    end

    // Sticky idle-bus error: any low bit after two quiet cycles; reset only
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            errReg <= 1'b0;
        end else if (quietNow && idleRun && (RN_BUS != '1)) begin
            errReg <= 1'b1;
        end
    end

    assign ERR = errReg;

endmodule

// File: tb/tb_rmux_capture_seq.sv
// tb_rmux_capture_seq
// Self-checking bench for rmux_capture_seq. A behavioural RMUX bank drives
// RN_BUS from the DUT strobes and bench-owned A/D vectors; expected captures
// are queued when requests are issued and popped when R_VLD is seen.
// Define RMUX_CAPTURE_PARITY_EN here as well to expect parity on R_PAR.

module tb_rmux_capture_seq;

    localparam int WIDTH  = 16;
    localparam int SETTLE = 2;

    logic             sysclk    = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic             REQ       = 1'b0;
    logic             SRC       = 1'b0;
    logic             CLR       = 1'b0;
    logic             RDY;
    logic             RA;
    logic             RD;
    logic [WIDTH-1:0] RN_BUS;
    logic [WIDTH-1:0] R_OUT;
    logic             R_VLD;
    logic             R_PAR;
    logic             ERR;

    logic [WIDTH-1:0] aVec       = '0;
    logic [WIDTH-1:0] dVec       = '0;
    logic [WIDTH-1:0] rnForceVal = '1;
    logic             rnForce    = 1'b0;

    logic [WIDTH-1:0] expQ[$];
    int               checkCount = 0;
    int               passCount  = 0;

    rmux_capture_seq #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .sysclk   (sysclk),
        .sys_rst_n(sys_rst_n),
        .REQ      (REQ),
        .SRC      (SRC),
        .RDY      (RDY),
        .RA       (RA),
        .RD       (RD),
        .RN_BUS   (RN_BUS),
        .CLR      (CLR),
        .R_OUT    (R_OUT),
        .R_VLD    (R_VLD),
        .R_PAR    (R_PAR),
        .ERR      (ERR)
    );

    // Behavioural RMUX bank, with an override for the idle-bus fault case
    assign RN_BUS = rnForce ? rnForceVal
                            : ~((aVec & {WIDTH{RA}}) | (dVec & {WIDTH{RD}}));

    always #5 sysclk = ~sysclk;

    // The two strobes must never be high together
    always @(negedge sysclk) begin
        assert (!(RA && RD))
            else $error("[TB] FAIL strobeExclusive RA=%b RD=%b required not both high", RA, RD);
    end

    function automatic logic expPar(input logic [WIDTH-1:0] v);
`ifdef RMUX_CAPTURE_PARITY_EN
        return ^v;
`else
        return 1'b0;
`endif
    endfunction

    // One-cycle request pulse; starts and ends just after a falling edge
    task automatic doReq(input logic src, input logic clr);
        REQ = 1'b1;
        SRC = src;
        CLR = clr;
        @(negedge sysclk);
        REQ = 1'b0;
        CLR = 1'b0;
        SRC = ~src;
    endtask

    // Bounded wait for R_VLD, counting strobe cycles seen on the way
    task automatic waitVld(output bit ok, output int n, output int raCnt, output int rdCnt);
        n = 0;
        raCnt = 0;
        rdCnt = 0;
        while (n < 40) begin
            raCnt += int'(RA);
            rdCnt += int'(RD);
            if (R_VLD) break;
            @(negedge sysclk);
            n++;
        end
        ok = R_VLD;
    endtask

    task automatic test_reset();
        #1;
        checkCount++; if (RDY !== 1'b1) $display("[TB] FAIL reset_rdy got=%b want=1", RDY); else passCount++;
        checkCount++; if (RA !== 1'b0) $display("[TB] FAIL reset_ra got=%b want=0", RA); else passCount++;
        checkCount++; if (RD !== 1'b0) $display("[TB] FAIL reset_rd got=%b want=0", RD); else passCount++;
        checkCount++; if (R_OUT !== 16'h0000) $display("[TB] FAIL reset_rout got=%h want=0000", R_OUT); else passCount++;
        checkCount++; if (R_VLD !== 1'b0) $display("[TB] FAIL reset_rvld got=%b want=0", R_VLD); else passCount++;
        checkCount++; if (R_PAR !== 1'b0) $display("[TB] FAIL reset_rpar got=%b want=0", R_PAR); else passCount++;
        checkCount++; if (ERR !== 1'b0) $display("[TB] FAIL reset_err got=%b want=0", ERR); else passCount++;
        @(negedge sysclk);
        @(negedge sysclk);
        sys_rst_n = 1'b1;
        @(negedge sysclk);
    endtask

    task automatic test_a_path();
        bit ok; int n, ra, rd; logic [WIDTH-1:0] e;
        aVec = 16'h1234;
        dVec = 16'hBEEF;
        expQ.push_back(16'h1234);
        doReq(1'b0, 1'b0);
        waitVld(ok, n, ra, rd);
        checkCount++; if (!ok) $display("[TB] FAIL a_vld_timeout got=0 want=1"); else passCount++;
        checkCount++; if (n != SETTLE + 1) $display("[TB] FAIL a_latency got=%0d want=%0d", n, SETTLE + 1); else passCount++;
        checkCount++; if (ra != SETTLE + 1) $display("[TB] FAIL a_ra_cycles got=%0d want=%0d", ra, SETTLE + 1); else passCount++;
        checkCount++; if (rd != 0) $display("[TB] FAIL a_rd_cycles got=%0d want=0", rd); else passCount++;
        @(negedge sysclk);
        e = expQ.pop_front();
        checkCount++; if (R_OUT !== e) $display("[TB] FAIL a_rout got=%h want=%h", R_OUT, e); else passCount++;
        checkCount++; if (R_PAR !== expPar(e)) $display("[TB] FAIL a_rpar got=%b want=%b", R_PAR, expPar(e)); else passCount++;
        checkCount++; if (R_VLD !== 1'b0) $display("[TB] FAIL a_vld_pulse got=%b want=0", R_VLD); else passCount++;
        checkCount++; if (RDY !== 1'b1) $display("[TB] FAIL a_rdy_back got=%b want=1", RDY); else passCount++;
        checkCount++; if (RA !== 1'b0) $display("[TB] FAIL a_ra_drop got=%b want=0", RA); else passCount++;
    endtask

    task automatic test_d_path();
        bit ok; int n, ra, rd; logic [WIDTH-1:0] e;
        aVec = 16'h00FF;
        dVec = 16'hFFFF;
        expQ.push_back(16'hFFFF);
        doReq(1'b1, 1'b0);
        waitVld(ok, n, ra, rd);
        checkCount++; if (!ok) $display("[TB] FAIL d_vld_timeout got=0 want=1"); else passCount++;
        checkCount++; if (rd != SETTLE + 1) $display("[TB] FAIL d_rd_cycles got=%0d want=%0d", rd, SETTLE + 1); else passCount++;
        checkCount++; if (ra != 0) $display("[TB] FAIL d_ra_cycles got=%0d want=0", ra); else passCount++;
        @(negedge sysclk);
        e = expQ.pop_front();
        checkCount++; if (R_OUT !== e) $display("[TB] FAIL d_rout_ffff got=%h want=%h", R_OUT, e); else passCount++;
        checkCount++; if (R_PAR !== expPar(e)) $display("[TB] FAIL d_rpar_ffff got=%b want=%b", R_PAR, expPar(e)); else passCount++;
        dVec = 16'h0001;
        expQ.push_back(16'h0001);
        doReq(1'b1, 1'b0);
        waitVld(ok, n, ra, rd);
        checkCount++; if (!ok) $display("[TB] FAIL d2_vld_timeout got=0 want=1"); else passCount++;
        @(negedge sysclk);
        e = expQ.pop_front();
        checkCount++; if (R_OUT !== e) $display("[TB] FAIL d_rout_0001 got=%h want=%h", R_OUT, e); else passCount++;
        checkCount++; if (R_PAR !== expPar(e)) $display("[TB] FAIL d_rpar_0001 got=%b want=%b", R_PAR, expPar(e)); else passCount++;
    endtask

    task automatic test_back_to_back();
        int busyLeft = 0;
        int vldCnt = 0;
        bit prevVld = 0;
        logic s;
        logic [WIDTH-1:0] e;
        for (int i = 0; i < 30; i++) begin
            if (prevVld && expQ.size() > 0) begin
                e = expQ.pop_front();
                checkCount++; if (R_OUT !== e) $display("[TB] FAIL b2b_rout cycle=%0d got=%h want=%h", i, R_OUT, e); else passCount++;
                checkCount++; if (R_PAR !== expPar(e)) $display("[TB] FAIL b2b_rpar cycle=%0d got=%b want=%b", i, R_PAR, expPar(e)); else passCount++;
            end
            prevVld = R_VLD;
            if (R_VLD) vldCnt++;
            checkCount++; if (RDY !== (busyLeft == 0)) $display("[TB] FAIL b2b_rdy cycle=%0d got=%b want=%b", i, RDY, busyLeft == 0); else passCount++;
            s   = 1'($urandom_range(0, 1));
            REQ = (i < 20);
            SRC = s;
            if (busyLeft == 0 && i < 20) begin
                aVec = 16'($urandom);
                dVec = 16'($urandom);
                expQ.push_back(s ? dVec : aVec);
                busyLeft = SETTLE + 2;
            end else if (busyLeft > 0) begin
                busyLeft--;
            end
            @(negedge sysclk);
        end
        REQ = 1'b0;
        checkCount++; if (vldCnt != 4) $display("[TB] FAIL b2b_captures got=%0d want=4", vldCnt); else passCount++;
        checkCount++; if (expQ.size() != 0) $display("[TB] FAIL b2b_queue_left got=%0d want=0", expQ.size()); else passCount++;
        checkCount++; if (ERR !== 1'b0) $display("[TB] FAIL b2b_err got=%b want=0", ERR); else passCount++;
    endtask

    task automatic test_reset_mid();
        bit ok; int n, ra, rd; int vldCnt = 0; logic [WIDTH-1:0] e;
        aVec = 16'h9999;
        doReq(1'b0, 1'b0);
        @(negedge sysclk);
        checkCount++; if (RA !== 1'b1) $display("[TB] FAIL mid_ra_before got=%b want=1", RA); else passCount++;
        #2;
        sys_rst_n = 1'b0;
        #1;
        checkCount++; if (RA !== 1'b0) $display("[TB] FAIL mid_ra_drop got=%b want=0", RA); else passCount++;
        checkCount++; if (RD !== 1'b0) $display("[TB] FAIL mid_rd_drop got=%b want=0", RD); else passCount++;
        checkCount++; if (RDY !== 1'b1) $display("[TB] FAIL mid_rdy got=%b want=1", RDY); else passCount++;
        checkCount++; if (R_OUT !== 16'h0000) $display("[TB] FAIL mid_rout got=%h want=0000", R_OUT); else passCount++;
        @(negedge sysclk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (R_VLD) vldCnt++;
            @(negedge sysclk);
        end
        checkCount++; if (vldCnt != 0) $display("[TB] FAIL mid_no_vld got=%0d want=0", vldCnt); else passCount++;
        checkCount++; if (R_OUT !== 16'h0000) $display("[TB] FAIL mid_rout_after got=%h want=0000", R_OUT); else passCount++;
        aVec = 16'h4321;
        expQ.push_back(16'h4321);
        doReq(1'b0, 1'b0);
        waitVld(ok, n, ra, rd);
        checkCount++; if (!ok) $display("[TB] FAIL mid_vld_timeout got=0 want=1"); else passCount++;
        @(negedge sysclk);
        e = expQ.pop_front();
        checkCount++; if (R_OUT !== e) $display("[TB] FAIL mid_rout_new got=%h want=%h", R_OUT, e); else passCount++;
    endtask

    task automatic test_clr();
        bit ok; int n, ra, rd; logic [WIDTH-1:0] e;
        aVec = 16'h1234;
        expQ.push_back(16'h1234);
        doReq(1'b0, 1'b0);
        waitVld(ok, n, ra, rd);
        @(negedge sysclk);
        e = expQ.pop_front();
        checkCount++; if (R_OUT !== e) $display("[TB] FAIL clr_setup got=%h want=%h", R_OUT, e); else passCount++;
        CLR = 1'b1;
        @(negedge sysclk);
        CLR = 1'b0;
        checkCount++; if (R_OUT !== 16'h0000) $display("[TB] FAIL clr_idle got=%h want=0000", R_OUT); else passCount++;
        checkCount++; if (R_PAR !== 1'b0) $display("[TB] FAIL clr_rpar got=%b want=0", R_PAR); else passCount++;
        checkCount++; if (R_VLD !== 1'b0) $display("[TB] FAIL clr_no_vld got=%b want=0", R_VLD); else passCount++;
        aVec = 16'hABCD;
        expQ.push_back(16'hABCD);
        doReq(1'b0, 1'b0);
        CLR = 1'b1;
        waitVld(ok, n, ra, rd);
        CLR = 1'b0;
        checkCount++; if (!ok) $display("[TB] FAIL clr_busy_timeout got=0 want=1"); else passCount++;
        @(negedge sysclk);
        e = expQ.pop_front();
        checkCount++; if (R_OUT !== e) $display("[TB] FAIL clr_busy_ignored got=%h want=%h", R_OUT, e); else passCount++;
        aVec = 16'h5A5A;
        expQ.push_back(16'h5A5A);
        doReq(1'b0, 1'b1);
        checkCount++; if (R_OUT !== 16'hABCD) $display("[TB] FAIL clr_req_wins_hold got=%h want=abcd", R_OUT); else passCount++;
        checkCount++; if (RDY !== 1'b0) $display("[TB] FAIL clr_req_accepted got=%b want=0", RDY); else passCount++;
        waitVld(ok, n, ra, rd);
        @(negedge sysclk);
        e = expQ.pop_front();
        checkCount++; if (R_OUT !== e) $display("[TB] FAIL clr_req_wins got=%h want=%h", R_OUT, e); else passCount++;
        checkCount++; if (R_PAR !== expPar(e)) $display("[TB] FAIL clr_req_rpar got=%b want=%b", R_PAR, expPar(e)); else passCount++;
    endtask

    task automatic test_idle_err();
        bit ok; int n, ra, rd; logic [WIDTH-1:0] e;
        @(negedge sysclk);
        @(negedge sysclk);
        checkCount++; if (ERR !== 1'b0) $display("[TB] FAIL err_clean got=%b want=0", ERR); else passCount++;
        rnForceVal = 16'hFFF7;
        rnForce = 1'b1;
        @(negedge sysclk);
        @(negedge sysclk);
        rnForce = 1'b0;
        checkCount++; if (ERR !== 1'b1) $display("[TB] FAIL err_set got=%b want=1", ERR); else passCount++;
        aVec = 16'h0F0F;
        expQ.push_back(16'h0F0F);
        doReq(1'b0, 1'b0);
        waitVld(ok, n, ra, rd);
        @(negedge sysclk);
        e = expQ.pop_front();
        checkCount++; if (R_OUT !== e) $display("[TB] FAIL err_capture got=%h want=%h", R_OUT, e); else passCount++;
        @(negedge sysclk);
        checkCount++; if (ERR !== 1'b1) $display("[TB] FAIL err_sticky got=%b want=1", ERR); else passCount++;
        sys_rst_n = 1'b0;
        #1;
        checkCount++; if (ERR !== 1'b0) $display("[TB] FAIL err_reset got=%b want=0", ERR); else passCount++;
        @(negedge sysclk);
        sys_rst_n = 1'b1;
        @(negedge sysclk);
    endtask

    initial begin
        test_reset();
        test_a_path();
        test_d_path();
        test_back_to_back();
        test_reset_mid();
        test_clr();
        test_idle_err();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Hard time limit so the bench always ends by itself
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/rmux_capture_seq.md
Name: rmux_capture_seq

Overview:
- Sequencer and holding register directly downstream of a WIDTH-wide bank of RMUX AND-NOR cells. Each cell computes RN = ~(A&RA | D&RD).
- Drives the shared RA/RD select strobes into the bank and waits a programmable settle time. It then samples the active-low RN bus, inverts it and holds the true value as the register-file write data for the CPU datapath.
- Single-request handshake with the microcode/control stage upstream; valid-pulse handshake to the register file downstream.

Parameters:
- WIDTH, 16, bit width of the RMUX bank and the held register.
- SETTLE, 2, cycles from strobe assertion to RN sample; legal range 1..15.

Ports:
- sysclk  input  1  system clock, all state on rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- REQ  input  1  capture request; accepted when REQ & RDY.
- SRC  input  1  source select sampled with REQ: 0 = A path (RA), 1 = D path (RD).
- RDY  output  1  block idle and able to accept REQ.
- RA  output  1  A-path strobe to all RMUX cells.
- RD  output  1  D-path strobe to all RMUX cells.
- RN_BUS  input  WIDTH  active-low results from the RMUX bank.
- CLR  input  1  synchronous clear of held value; ignored while busy.
- R_OUT  output  WIDTH  held (true-polarity) captured value.
- R_VLD  output  1  one-cycle pulse when R_OUT updates.
- R_PAR  output  1  even parity of R_OUT (optional feature).
- ERR  output  1  sticky: idle-bus check failed.

Behaviour:
- Reset (async, sys_rst_n=0): state IDLE, RA=0, RD=0, RDY=1, R_OUT=0, R_VLD=0, R_PAR=0, ERR=0, settle counter=0. Takes effect immediately, including mid-operation. Strobes drop combinationally-asynchronously with reset, and no capture occurs.
- States: IDLE, STROBE, SETTLE, CAPT.
- IDLE: RDY=1, RA=RD=0.
  - On REQ: latch SRC, go to STROBE.
  - On CLR without REQ: R_OUT<=0 next cycle, no R_VLD.
  - On REQ and CLR together: REQ wins, CLR is dropped.
- STROBE: RDY=0. Assert RA (SRC=0) or RD (SRC=1), never both. Load counter with SETTLE-1. Go to SETTLE.
- SETTLE: strobe held; counter decrements. At 0, go to CAPT.
- CAPT: strobe still held. R_OUT<=~RN_BUS, R_VLD=1 for exactly this one cycle. Strobe deasserts on the next edge; return to IDLE.
- Latency: REQ accepted at edge n. The strobe is high from edge n+1. R_OUT is valid after edge n+SETTLE+2, with R_VLD high in the cycle ending at that edge. Back-to-back: next REQ is accepted on the first IDLE cycle, giving a throughput of one capture per SETTLE+3 cycles.
- REQ while RDY=0 is ignored, not queued. SRC changes while busy have no effect.
- Strobe exclusivity: RA&RD never 1 in any cycle. Assertion required in the bench.
- Idle-bus check: in IDLE with no strobe for ≥2 consecutive cycles, RN_BUS must be all ones. Any zero bit sets ERR. ERR is cleared only by reset.
- Counter width is 4 bits. SETTLE=1 passes through SETTLE for exactly one cycle (counter loads 0).
- R_OUT is unaffected by everything except CAPT, CLR and reset.

Optional Feature:
- Macro RMUX_CAPTURE_PARITY_EN.
- Defined: R_PAR register updated with R_OUT. In CAPT it takes ^(~RN_BUS); on CLR or reset it takes 0. It is valid on the same edge as R_OUT.
- Undefined: R_PAR tied to 0, no parity logic synthesised; port still present.

Test Plan:
- Reset then SRC=0 REQ, A path, RN_BUS=16'hEDCB (WIDTH=16, SETTLE=2) -> RA high 3 cycles, RD=0, R_OUT=16'h1234 with R_VLD pulse 4 cycles after accept, RDY back to 1 next cycle.
- SRC=1 REQ, RN_BUS=16'h0000 -> RD strobe only, R_OUT=16'hFFFF; with parity macro R_PAR=0; RN_BUS=16'hFFFE gives R_OUT=16'h0001, R_PAR=1.
- REQ pulsed every cycle for 20 cycles -> exactly 4 captures (period 5 at SETTLE=2), strobes never overlap, extra REQs dropped.
- Assert sys_rst_n=0 during SETTLE -> RA/RD drop immediately, R_OUT stays 0, no R_VLD; after release RDY=1 and a new REQ completes normally.
- CLR with R_OUT=16'h1234 in IDLE -> R_OUT=0, no R_VLD. Then CLR held during busy -> ignored, capture completes. Then REQ+CLR same cycle -> capture proceeds.
- In IDLE drive RN_BUS=16'hFFF7 for 2 cycles -> ERR=1 and stays 1 through further captures until reset.
